// File: rtl/rv32i_pkg.sv
// Shared types, constants and the load-data extraction helper for the writeback slice.
package rv32i_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic [1:0]            offset;
  } lq_entry_t;

  // Reserved funct3 encodings fall through to a full-word load.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [2:0]      funct3,
    input logic [1:0]      offset,
    input logic [XLEN-1:0] word
  );
    logic [XLEN-1:0] shifted;
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] result;
    shifted = word >> {offset, 3'b000};
    b       = shifted[7:0];
    h       = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      result = {{24{b[7]}}, b};
      LBU:     result = {24'h000000, b};
      LH:      result = {{16{h[15]}}, h};
      LHU:     result = {16'h0000, h};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rv32i_load_queue.sv
// In-order FIFO of outstanding loads; exposes per-slot valid/rd for hazard tracking.
module rv32i_load_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_push,
  input  lq_entry_t                           i_push_entry,
  input  logic                                i_pop,
  output logic                                o_full,
  output logic                                o_empty,
  output lq_entry_t                           o_head,
  output logic [DEPTH-1:0]                    o_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    o_rd
);

  localparam int PTR_W = $clog2(DEPTH);

  lq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [DEPTH-1:0] r_valid;
  logic             w_push;
  logic             w_pop;

  assign o_full  = &r_valid;
  assign o_empty = ~|r_valid;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = r_valid;

  // When full, push and pop hit the same slot; the push's set must win.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd
      assign o_rd[gi] = r_mem[gi].rd;
    end
  endgenerate

endmodule

// File: rtl/rv32i_writeback.sv
// Register-file write-port arbiter: load responses beat ALU results; tracks loads in flight.
module rv32i_writeback
  import rv32i_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  load_issue_valid,
  output logic                  load_issue_ready,
  input  logic [REG_ADDR_W-1:0] load_issue_rd,
  input  logic [2:0]            load_issue_funct3,
  input  logic [1:0]            load_issue_offset,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [XLEN-1:0]       busy_mask,
  output logic                  lq_underflow,
  output logic [XLEN-1:0]       write_data,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic                  write_enable
);

  logic                               w_lq_full;
  logic                               w_lq_empty;
  logic                               w_push;
  lq_entry_t                          w_push_entry;
  lq_entry_t                          w_head;
  logic [LQ_DEPTH-1:0]                w_lq_valid;
  logic [LQ_DEPTH-1:0][REG_ADDR_W-1:0] w_lq_rd;
  logic [XLEN-1:0]                    w_busy;

  logic [XLEN-1:0]       r_wdata;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic                  r_we;
  logic                  r_underflow;

  assign alu_ready        = ~mem_rvalid;
  assign load_issue_ready = ~w_lq_full | mem_rvalid;
  assign w_push           = load_issue_valid & load_issue_ready;
  assign w_push_entry     = '{rd: load_issue_rd, funct3: load_issue_funct3,
                              offset: load_issue_offset};

  rv32i_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (mem_rvalid),
    .o_full       (w_lq_full),
    .o_empty      (w_lq_empty),
    .o_head       (w_head),
    .o_valid      (w_lq_valid),
    .o_rd         (w_lq_rd)
  );

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (w_lq_valid[i]) w_busy[w_lq_rd[i]] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end
  assign busy_mask = w_busy;

  // x0 destinations consume their slot but never raise the write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_wreg      <= '0;
      r_wdata     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (mem_rvalid) begin
        if (w_lq_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_wreg  <= w_head.rd;
          r_wdata <= load_extract(w_head.funct3, w_head.offset, mem_rdata);
          r_we    <= (w_head.rd != '0);
        end
      end else if (alu_valid) begin
        r_wreg  <= alu_rd;
        r_wdata <= alu_data;
        r_we    <= (alu_rd != '0);
      end
    end
  end

  assign write_enable   = r_we;
  assign write_register = r_wreg;
  assign write_data     = r_wdata;
  assign lq_underflow   = r_underflow;

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed bench with a queue-based reference model checked every cycle plus literal pins.
module tb_rv32i_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_issue_valid;
  logic        load_issue_ready;
  logic [4:0]  load_issue_rd;
  logic [2:0]  load_issue_funct3;
  logic [1:0]  load_issue_offset;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] busy_mask;
  logic        lq_underflow;
  logic [31:0] write_data;
  logic [4:0]  write_register;
  logic        write_enable;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  always #5 clk = ~clk;

  rv32i_writeback #(.LQ_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .alu_valid         (alu_valid),
    .alu_ready         (alu_ready),
    .alu_rd            (alu_rd),
    .alu_data          (alu_data),
    .load_issue_valid  (load_issue_valid),
    .load_issue_ready  (load_issue_ready),
    .load_issue_rd     (load_issue_rd),
    .load_issue_funct3 (load_issue_funct3),
    .load_issue_offset (load_issue_offset),
    .mem_rvalid        (mem_rvalid),
    .mem_rdata         (mem_rdata),
    .busy_mask         (busy_mask),
    .lq_underflow      (lq_underflow),
    .write_data        (write_data),
    .write_register    (write_register),
    .write_enable      (write_enable)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          rd;
    logic [2:0]  f3;
    int          off;
  } m_entry_t;

  m_entry_t    mq[$];
  logic        m_started = 1'b0;
  logic        m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic        m_known;
  logic        m_uf;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    longint v;
    case (f3)
      3'b000, 3'b100: begin
        v = longint'((w >> (8 * off)) & 32'hFF);
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_busy();
    logic [31:0] m;
    m = 32'h0;
    foreach (mq[i]) if (mq[i].rd != 0) m = m | (32'h1 << mq[i].rd);
    return m;
  endfunction

  always @(posedge clk) begin
    m_entry_t e;
    logic     push;
    m_started = 1'b1;
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_wreg = '0; m_wdata = '0; m_known = 1'b1; m_uf = 1'b0;
    end else begin
      push = load_issue_valid && (mq.size() < 4 || mem_rvalid);
      m_we = 1'b0;
      if (mem_rvalid) begin
        if (mq.size() == 0) begin
          m_uf = 1'b1;
        end else begin
          e = mq.pop_front();
          if (e.rd != 0) begin
            m_we = 1'b1; m_wreg = 5'(e.rd); m_wdata = ref_load(e.f3, e.off, mem_rdata); m_known = 1'b1;
          end else begin
            m_known = 1'b0;
          end
        end
      end else if (alu_valid) begin
        if (alu_rd != 0) begin
          m_we = 1'b1; m_wreg = alu_rd; m_wdata = alu_data; m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end
      if (push) begin
        e.rd = int'(load_issue_rd); e.f3 = load_issue_funct3; e.off = int'(load_issue_offset);
        mq.push_back(e);
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      cmp("write_enable", {31'b0, write_enable}, {31'b0, m_we});
      if (m_known) begin
        cmp("write_register", {27'b0, write_register}, {27'b0, m_wreg});
        cmp("write_data", write_data, m_wdata);
      end
      cmp("busy_mask", busy_mask, ref_busy());
      cmp("lq_underflow", {31'b0, lq_underflow}, {31'b0, m_uf});
      cmp("alu_ready", {31'b0, alu_ready}, {31'b0, !mem_rvalid});
      cmp("load_issue_ready", {31'b0, load_issue_ready},
          {31'b0, (mq.size() < 4) || mem_rvalid});
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [2:0] lf3,
                       input logic [1:0] loff, input logic mv, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    load_issue_valid = lv; load_issue_rd = lrd; load_issue_funct3 = lf3; load_issue_offset = loff;
    mem_rvalid = mv; mem_rdata = md;
    txn++;
    $display("txn %0d: rst=%0b alu=%0b rd=%0d data=%h | issue=%0b rd=%0d f3=%0d off=%0d | rvalid=%0b rdata=%h",
             txn, reset, av, ard, ad, lv, lrd, lf3, loff, mv, md);
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_rsp(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word,
                          input logic [31:0] exp, input string name);
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, f3, off, 1'b0, 32'h0);
    tick();
    cmp({name, "_busy"}, busy_mask, 32'h0000_0008);
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, word);
    tick();
    cmp({name, "_data"}, write_data, exp);
    cmp({name, "_we"}, {31'b0, write_enable}, 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    cmp("rst_we", {31'b0, write_enable}, 32'h0);
    cmp("rst_wdata", write_data, 32'h0);
    cmp("rst_busy", busy_mask, 32'h0);
    reset = 1'b0;

    // ALU path
    apply(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
    #1 cmp("t1_alu_ready", {31'b0, alu_ready}, 32'h1);
    tick();
    cmp("t1_wreg", {27'b0, write_register}, 32'd5);
    cmp("t1_wdata", write_data, 32'h1234_5678);
    idle();
    tick();

    // extraction
    load_rsp(3'b000, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF, "lb");
    load_rsp(3'b100, 2'd2, 32'h80FF_7F01, 32'h0000_00FF, "lbu");
    load_rsp(3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, "lh");
    load_rsp(3'b101, 2'd0, 32'h80FF_7F01, 32'h0000_7F01, "lhu");
    load_rsp(3'b001, 2'd3, 32'h7FFF_0000, 32'h0000_7FFF, "lh_off3");
    load_rsp(3'b111, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rsvd");
    idle();
    tick();

    // collision
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 3'b010, 2'd0, 1'b0, 32'h0);
    tick();
    apply(1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'hCAFE_BABE);
    #1 cmp("t3_alu_ready", {31'b0, alu_ready}, 32'h0);
    tick();
    cmp("t3_load_wreg", {27'b0, write_register}, 32'd9);
    cmp("t3_load_wdata", write_data, 32'hCAFE_BABE);
    apply(1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
    tick();
    cmp("t3_alu_wreg", {27'b0, write_register}, 32'd7);
    cmp("t3_alu_wdata", write_data, 32'h0000_0777);

    // full queue
    for (int r = 1; r <= 4; r++) begin
      apply(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 3'b010, 2'd0, 1'b0, 32'h0);
      tick();
    end
    idle();
    #1 cmp("t4_full_ready", {31'b0, load_issue_ready}, 32'h0);
    cmp("t4_full_busy", busy_mask, 32'h0000_001E);
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 3'b010, 2'd0, 1'b1, 32'h1111_1111);
    #1 cmp("t4_pp_ready", {31'b0, load_issue_ready}, 32'h1);
    tick();
    cmp("t4_pp_wreg", {27'b0, write_register}, 32'd1);
    cmp("t4_pp_busy", busy_mask, 32'h0000_005C);
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h2000_0000 + 32'(k));
      tick();
    end
    cmp("t4_drained_busy", busy_mask, 32'h0);

    // same rd twice
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 3'b010, 2'd0, 1'b0, 32'h0);
    tick();
    tick();
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h0000_0088);
    tick();
    cmp("t5_after_first", busy_mask & 32'h100, 32'h100);
    tick();
    cmp("t5_after_second", busy_mask & 32'h100, 32'h0);

    // x0 load
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 3'b010, 2'd0, 1'b0, 32'h0);
    tick();
    cmp("t6_x0_busy", busy_mask, 32'h0);
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h5555_5555);
    tick();
    cmp("t6_x0_we", {31'b0, write_enable}, 32'h0);
    cmp("t6_x0_uf", {31'b0, lq_underflow}, 32'h0);

    // underflow with simultaneous push
    apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 3'b010, 2'd0, 1'b1, 32'h6666_6666);
    tick();
    cmp("t6_uf_set", {31'b0, lq_underflow}, 32'h1);
    cmp("t6_uf_we", {31'b0, write_enable}, 32'h0);
    cmp("t6_uf_push_busy", busy_mask, 32'h0000_0400);
    idle();
    tick();
    cmp("t6_uf_sticky", {31'b0, lq_underflow}, 32'h1);

    // reset discards queue
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("t6_rst_busy", busy_mask, 32'h0);
    cmp("t6_rst_uf", {31'b0, lq_underflow}, 32'h0);
    cmp("t6_rst_wreg", {27'b0, write_register}, 32'h0);
    apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h7777_7777);
    tick();
    cmp("t6_post_rst_uf", {31'b0, lq_underflow}, 32'h1);
    cmp("t6_post_rst_we", {31'b0, write_enable}, 32'h0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
